// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
// Holds size encodings, the FSM state type and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Lane enables for 2^size bytes starting at byte offset off.
    // Callers narrow the result to XLEN/8 bits.
    function automatic logic [7:0] byte_mask(input logic [1:0] size,
                                             input logic [2:0] off);
        logic [7:0] base;
        unique case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request/response bundle between CPU and dmem_ctrl.
// master = CPU side (drives req_*, rsp_ready); slave = controller side.
interface dmem_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size,
        output req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size,
        input  req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_ctrl.
// Ports: size/off/sgn/mask/wdata/old_word in; new_word (store merge), ld_data out.
module dmem_lane_align #(
    parameter int XLEN = 64
) (
    input  logic [1:0]        size,
    input  logic [2:0]        off,
    input  logic              sgn,
    input  logic [XLEN/8-1:0] mask,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   old_word,
    output logic [XLEN-1:0]   new_word,
    output logic [XLEN-1:0]   ld_data
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] wsh;
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] msb;
    logic            sbit;
    int              nbits;

    always_comb begin
        wsh = wdata << {off, 3'b000};
        for (int i = 0; i < NB; i++) begin
            new_word[i*8 +: 8] = mask[i] ? wsh[i*8 +: 8] : old_word[i*8 +: 8];
        end

        rsh   = old_word >> {off, 3'b000};
        nbits = 8 << size;
        if (nbits > XLEN) nbits = XLEN;
        keep  = {XLEN{1'b1}} >> (XLEN - nbits);
        // Top bit of the kept field is the sign bit of the loaded value.
        msb   = keep & ~(keep >> 1);
        sbit  = |(rsh & msb);
        ld_data = (rsh & keep) | ((sgn && sbit) ? ~keep : '0);
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-stated data-memory controller with sub-word access.
// Ports: clk, rst (async active-low), bus (dmem_if.slave), busy.
// Optional DMEM_ALIGN_CHECK_EN: fault misaligned accesses instead of aligning down.
module dmem_ctrl import dmem_pkg::*; #(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output logic   busy
);
    localparam int NB    = XLEN / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              sgn_q, sgn_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0] idx;
    logic [2:0]       off, amask, eoff;
    logic             oor, illsz, misal, fault, mem_we;
    logic [NB-1:0]    mask;
    logic [XLEN-1:0]  old_word, new_word, ld_data;

    assign idx      = addr_q[OFF +: IDX_W];
    assign off      = 3'(addr_q[OFF-1:0]);
    assign amask    = 3'((4'd1 << size_q) - 4'd1);
    assign oor      = |(addr_q >> (OFF + IDX_W));
    assign illsz    = (XLEN == 32) && (size_q == SZ_D);
`ifdef DMEM_ALIGN_CHECK_EN
    assign misal    = |(off & amask);
    assign eoff     = off;
`else
    assign misal    = 1'b0;
    assign eoff     = off & ~amask;
`endif
    assign fault    = oor | illsz | misal;
    assign mask     = NB'(byte_mask(size_q, eoff));
    assign old_word = mem_q[idx];

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .size     (size_q),
        .off      (eoff),
        .sgn      (sgn_q),
        .mask     (mask),
        .wdata    (wdata_q),
        .old_word (old_word),
        .new_word (new_word),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        sgn_d   = sgn_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    write_d = bus.req_write;
                    sgn_d   = bus.req_signed;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = write_q && !fault;
                    rdata_d = (write_q || fault) ? '0 : ld_data;
                    err_d   = fault;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_B;
            write_q <= 1'b0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside reset; reset forces IDLE, so a
    // pending write never reaches its access edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= new_word;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl (XLEN=64, DEPTH=1024, WAIT_STATES=2).
// Covers reset, latency, sub-word, back-pressure, throughput, range and alignment.
module tb_dmem_ctrl;
    localparam int XLEN   = 64;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 64;
    localparam int WS     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    dmem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(WS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic w, input logic [63:0] a,
                         input logic [1:0] sz, input logic sg,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic er, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        logic er;
        int lat;
        vec_cnt++;
        if (bus.req_ready !== 1'b1) begin
            err_cnt++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready);
        end
        vec_cnt++;
        if (bus.rsp_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid);
        end
        vec_cnt++;
        if (bus.rsp_rdata !== 64'h0) begin
            err_cnt++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata);
        end
        vec_cnt++;
        if (bus.rsp_err !== 1'b0) begin
            err_cnt++; $display("FAIL rst_err: got %b want 0", bus.rsp_err);
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        @(negedge clk); rst = 1'b1;

        issue(1'b1, 64'h10, 2'd3, 1'b0, 64'hAAAA5555_01234567, rd, er, lat);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h10;
        bus.req_size = 2'd3; bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_state: got valid=%b ready=%b want 0/1",
                     bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk); rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vec_cnt++;
        if (bus.rsp_valid !== 1'b0) begin
            err_cnt++; $display("FAIL midrst_norsp: got %b want 0", bus.rsp_valid);
        end
        issue(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'hAAAA5555_01234567) begin
            err_cnt++; $display("FAIL midrst_word: got %h want aaaa555501234567", rd);
        end
    endtask

    task automatic test_latency();
        logic [63:0] rd;
        logic er;
        int lat;
        issue(1'b1, 64'h8, 2'd3, 1'b0, 64'h1122334455667788, rd, er, lat);
        vec_cnt++;
        if (lat !== WS + 1 || er !== 1'b0 || rd !== 64'h0) begin
            err_cnt++;
            $display("FAIL st_lat: got lat=%0d err=%b rd=%h want %0d/0/0",
                     lat, er, rd, WS + 1);
        end
        issue(1'b0, 64'h8, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (lat !== WS + 1) begin
            err_cnt++; $display("FAIL ld_lat: got %0d want %0d", lat, WS + 1);
        end
        vec_cnt++;
        if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
            err_cnt++; $display("FAIL ld_data: got %h err=%b want 1122334455667788", rd, er);
        end
    endtask

    task automatic test_subword();
        logic [63:0] rd;
        logic er;
        int lat;
        issue(1'b1, 64'h8, 2'd3, 1'b0, 64'h0, rd, er, lat);
        issue(1'b1, 64'h9, 2'd0, 1'b0, 64'hF0, rd, er, lat);
        issue(1'b0, 64'h9, 2'd0, 1'b1, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFF0) begin
            err_cnt++; $display("FAIL lb_signed: got %h want fffffffffffffff0", rd);
        end
        issue(1'b0, 64'h9, 2'd0, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'hF0) begin
            err_cnt++; $display("FAIL lb_unsigned: got %h want f0", rd);
        end
        issue(1'b0, 64'h8, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'h000000000000F000) begin
            err_cnt++; $display("FAIL ld_after_sb: got %h want f000", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd;
        logic er;
        int lat;
        int guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h8;
        bus.req_size = 2'd3; bus.req_signed = 1'b0; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        vec_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'hF000) begin
            err_cnt++;
            $display("FAIL bp_first: got valid=%b rd=%h want 1/f000",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        bus.req_write = 1'b1;
        bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = (i == 2);
            @(posedge clk); #1;
            vec_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'hF000 ||
                bus.rsp_err !== 1'b0) begin
                err_cnt++;
                $display("FAIL bp_stable[%0d]: got v=%b rd=%h e=%b want 1/f000/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
            end
            vec_cnt++;
            if (bus.req_ready !== 1'b0) begin
                err_cnt++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.req_ready);
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_release: got ready=%b valid=%b want 1/0",
                     bus.req_ready, bus.rsp_valid);
        end
        issue(1'b0, 64'h8, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'hF000) begin
            err_cnt++; $display("FAIL bp_ignored_store: got %h want f000", rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h8;
        bus.req_size = 2'd3; bus.req_signed = 1'b0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.req_ready) acc.push_back(i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        while (!bus.req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        vec_cnt++;
        if (acc.size() !== 3) begin
            err_cnt++; $display("FAIL b2b_count: got %0d want 3", acc.size());
        end
        // Accept, WS countdown edges, access edge, handshake edge, then next accept.
        if (acc.size() >= 2) begin
            vec_cnt++;
            if (acc[1] - acc[0] !== WS + 3) begin
                err_cnt++; $display("FAIL b2b_gap: got %0d want %0d", acc[1] - acc[0], WS + 3);
            end
        end
    endtask

    task automatic test_range();
        logic [63:0] rd;
        logic er;
        int lat;
        issue(1'b1, 64'h0, 2'd3, 1'b0, 64'h0123456789ABCDEF, rd, er, lat);
        issue(1'b0, 64'h2000, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (er !== 1'b1 || rd !== 64'h0 || lat !== WS + 1) begin
            err_cnt++;
            $display("FAIL oor_load: got err=%b rd=%h lat=%0d want 1/0/%0d", er, rd, lat, WS + 1);
        end
        issue(1'b1, 64'h2000, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
        vec_cnt++;
        if (er !== 1'b1) begin
            err_cnt++; $display("FAIL oor_store_err: got %b want 1", er);
        end
        issue(1'b0, 64'h0, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
            err_cnt++; $display("FAIL oor_word0: got %h err=%b want 0123456789abcdef", rd, er);
        end
    endtask

    task automatic test_align();
        logic [63:0] rd;
        logic er;
        int lat;
        logic        exp_err;
        logic [63:0] exp_word;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 64'h0;
`else
        exp_err  = 1'b0;
        exp_word = 64'h00000000_BEEF0000;
`endif
        issue(1'b1, 64'h0, 2'd3, 1'b0, 64'h0, rd, er, lat);
        issue(1'b1, 64'h3, 2'd1, 1'b0, 64'hBEEF, rd, er, lat);
        vec_cnt++;
        if (er !== exp_err || lat !== WS + 1) begin
            err_cnt++;
            $display("FAIL align_err: got err=%b lat=%0d want %b/%0d", er, lat, exp_err, WS + 1);
        end
        issue(1'b0, 64'h0, 2'd3, 1'b0, 64'h0, rd, er, lat);
        vec_cnt++;
        if (rd !== exp_word) begin
            err_cnt++; $display("FAIL align_word: got %h want %h", rd, exp_word);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_subword();
        test_backpressure();
        test_back_to_back();
        test_range();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
